// File: rtl/ntt_pkg.sv
// ============================================================================
// Module  : ntt_pkg
// Purpose : Shared FSM state encoding and index helpers for ntt_bram_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ntt_pkg;

    localparam int MAX_IDX_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LAUNCH = 3'd2,
        CORE   = 3'd3,
        WRITE  = 3'd4,
        FIN    = 3'd5
    } ntt_state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Reverse all MAX_IDX_W bits, then drop the unused low end.
    function automatic logic [MAX_IDX_W-1:0] bitrev(input logic [MAX_IDX_W-1:0] v,
                                                    input int bits);
        logic [MAX_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_IDX_W; i++) begin
            r[i] = v[MAX_IDX_W-1-i];
        end
        return r >> (MAX_IDX_W - bits);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_rd_pipe.sv
// ============================================================================
// Module  : bram_rd_pipe
// Purpose : RD_LAT-deep valid/index pipe tagging BRAM reads until data returns.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_rd_pipe #(
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             cap_o,
    output logic [IDX_W-1:0] cap_idx_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [IDX_W-1:0]  idx_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue_i;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        idx_q[0] <= idx_i;
        for (int s = 1; s < RD_LAT; s++) begin
            idx_q[s] <= idx_q[s-1];
        end
    end

    assign cap_o     = vld_q[RD_LAT-1];
    assign cap_idx_o = idx_q[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/ntt_bram_ctrl.sv
// ============================================================================
// Module  : ntt_bram_ctrl
// Purpose : Streams N words BRAM->operand buffer, launches the NTT core, writes
//           results back. Define BITREV_WB_EN for bit-reversed write-back order.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_bram_ctrl
    import ntt_pkg::*;
#(
    parameter int N          = 64,
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 2,
    parameter int ADDR_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_base,
    input  logic [ADDR_W-1:0]     dst_base,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic                  bram_en,
    output logic [DATA_W/8-1:0]   bram_we,
    output logic [DATA_W-1:0]     bram_din,
    input  logic [DATA_W-1:0]     bram_dout,
    output logic [N*DATA_W-1:0]   core_x,
    output logic                  core_start,
    input  logic [N*DATA_W-1:0]   core_y,
    input  logic                  core_done
);

    localparam int             IW     = idx_w(N);
    localparam int             CW     = IW + 1;
    localparam logic [CW-1:0]  C_N    = CW'(N);
    localparam logic [CW-1:0]  C_LAST = CW'(N - 1);

    ntt_state_t          state_q, state_d;
    logic [CW-1:0]       rd_i_q, rd_i_d, cap_i_q, cap_i_d, wr_j_q, wr_j_d;
    logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [DATA_W-1:0]   x_q [N];
    logic [DATA_W-1:0]   y_w [N];

    logic                w_issue, w_wr, w_cap;
    logic [IW-1:0]       w_cap_idx, w_sel;
    logic [ADDR_W-1:0]   w_word;

    assign w_issue = (state_q == READ) && (rd_i_q < C_N);
    assign w_wr    = (state_q == WRITE);

    bram_rd_pipe #(
        .RD_LAT (RD_LAT),
        .IDX_W  (IW)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue_i   (w_issue),
        .idx_i     (rd_i_q[IW-1:0]),
        .cap_o     (w_cap),
        .cap_idx_o (w_cap_idx)
    );

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign core_x[k*DATA_W +: DATA_W] = x_q[k];
        assign y_w[k]                     = core_y[k*DATA_W +: DATA_W];
    end

`ifdef BITREV_WB_EN
    assign w_sel = IW'(bitrev(MAX_IDX_W'(wr_j_q[IW-1:0]), IW));
`else
    assign w_sel = wr_j_q[IW-1:0];
`endif

    always_comb begin
        state_d = state_q;
        rd_i_d  = rd_i_q;
        cap_i_d = cap_i_q;
        wr_j_d  = wr_j_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    src_d   = src_base;
                    dst_d   = dst_base;
                    rd_i_d  = '0;
                    cap_i_d = '0;
                end
            end
            READ: begin
                if (w_issue) rd_i_d = rd_i_q + 1'b1;
                if (w_cap) begin
                    cap_i_d = cap_i_q + 1'b1;
                    if (cap_i_q == C_LAST) state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = CORE;
            // core_done is only looked at from here on, so a level left high
            // by the previous run has already been cleared by core_start.
            CORE: begin
                if (core_done) begin
                    state_d = WRITE;
                    wr_j_d  = '0;
                end
            end
            WRITE: begin
                wr_j_d = wr_j_q + 1'b1;
                if (wr_j_q == C_LAST) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_i_q  <= '0;
            cap_i_q <= '0;
            wr_j_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_i_q  <= rd_i_d;
            cap_i_q <= cap_i_d;
            wr_j_q  <= wr_j_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && (state_q == READ) && w_cap) begin
            x_q[w_cap_idx] <= bram_dout;
        end
    end

    assign w_word     = (state_q == READ) ? (src_q + ADDR_W'(rd_i_q))
                                          : (dst_q + ADDR_W'(wr_j_q));
    assign bram_en    = w_issue | w_wr;
    assign bram_addr  = bram_en ? (w_word << ADDR_SHIFT) : '0;
    assign bram_we    = {(DATA_W/8){w_wr}};
    assign bram_din   = w_wr ? y_w[w_sel] : '0;
    assign busy       = (state_q == READ) || (state_q == LAUNCH) ||
                        (state_q == CORE) || (state_q == WRITE);
    assign done       = (state_q == FIN);
    assign core_start = (state_q == LAUNCH);

endmodule

`default_nettype wire

// File: tb/tb_ntt_bram_ctrl.sv
// ============================================================================
// Module  : tb_ntt_bram_ctrl
// Purpose : Directed self-checking bench for ntt_bram_ctrl (N=8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ntt_bram_ctrl;

    localparam int N = 8, DW = 64, AW = 10, SH = 2, LAT = 2, XW = N * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, start, sw_start, sw_go;
    logic [AW-1:0]      src_base, dst_base, bram_addr;
    logic               busy, done, bram_en, core_start, core_done;
    logic [DW/8-1:0]    bram_we;
    logic [DW-1:0]      bram_din, bram_dout;
    logic [XW-1:0]      core_x, core_y, exp_x;

    int checks = 0, errors = 0;
    int we_cnt = 0, we_bad = 0, done_cnt = 0;

    ntt_bram_ctrl #(.N(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .ADDR_SHIFT(SH)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
        .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_din(bram_din), .bram_dout(bram_dout), .core_x(core_x), .core_start(core_start),
        .core_y(core_y), .core_done(core_done)
    );

    task automatic chk(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XW-1:0] exp_src(input logic [DW-1:0] v0);
        logic [XW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = v0 + DW'(k);
        return r;
    endfunction

    // Expected word at dst_base+j when source word k held v0+k.
    function automatic logic [DW-1:0] exp_wb(input int j, input logic [DW-1:0] v0);
        logic [2:0] jj;
        jj = 3'(j);
`ifdef BITREV_WB_EN
        return {61'd0, jj[0], jj[1], jj[2]};
`else
        return 2 * (v0 + DW'(jj));
`endif
    endfunction

    // BRAM model: word-addressed, RD_LAT-cycle read pipe.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rp [4];
    logic [7:0]    w_word;
    assign w_word    = bram_addr[AW-1:SH];
    assign bram_dout = rp[LAT-1];
    always @(posedge clk) begin
        rp[0] <= (bram_en && bram_we == '0) ? mem[w_word] : '0;
        for (int s = 1; s < 4; s++) rp[s] <= rp[s-1];
        if (bram_en)
            for (int b = 0; b < DW/8; b++)
                if (bram_we[b]) mem[w_word][b*8 +: 8] = bram_din[b*8 +: 8];
    end

    // Core model: result valid 5 edges after core_start, held until next start.
    int   ccnt;
    logic cdone_q;
    logic [XW-1:0] y_q;
    assign core_done = cdone_q;
    assign core_y    = y_q;
    always @(posedge clk) begin
        if (!rst_n) begin
            cdone_q <= 1'b0;
            ccnt    <= 0;
        end else if (core_start) begin
            cdone_q <= 1'b0;
            ccnt    <= 5;
            for (int k = 0; k < N; k++)
`ifdef BITREV_WB_EN
                y_q[k*DW +: DW] <= DW'(k);
`else
                y_q[k*DW +: DW] <= core_x[k*DW +: DW] << 1;
`endif
        end else if (ccnt != 0) begin
            ccnt <= ccnt - 1;
            if (ccnt == 1) cdone_q <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bram_we != '0) begin
            we_cnt++;
            if (!busy || !bram_en || bram_we != 8'hFF) we_bad++;
        end
        if (done) done_cnt++;
    end

    task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d);
        @(negedge clk);
        src_base = s;
        dst_base = d;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the number of rising edges from the accepting edge through done.
    task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, output int cyc);
        launch(s, d);
        cyc = 1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (cyc >= 300) begin
                chk("done_timeout", done, 1);
                break;
            end
            @(posedge clk);
            cyc++;
        end
    endtask

    // RD_LAT sweep: one controller per latency, shared start, no core.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lat
        localparam int L = gi + 1;
        logic          s_busy, s_done, s_en, s_cs;
        logic [AW-1:0] s_addr;
        logic [DW/8-1:0] s_we;
        logic [DW-1:0] s_din, s_dout;
        logic [XW-1:0] s_x, s_y;
        logic [DW-1:0] sp [4];
        assign s_y    = '0;
        assign s_dout = sp[L-1];
        always @(posedge clk) begin
            sp[0] <= s_en ? (DW'(s_addr[AW-1:SH]) - 64'h0F) : '0;
            for (int s = 1; s < 4; s++) sp[s] <= sp[s-1];
        end
        ntt_bram_ctrl #(.N(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(L), .ADDR_SHIFT(SH)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(sw_start), .src_base(10'h010), .dst_base(10'h040),
            .busy(s_busy), .done(s_done), .bram_addr(s_addr), .bram_en(s_en), .bram_we(s_we),
            .bram_din(s_din), .bram_dout(s_dout), .core_x(s_x), .core_start(s_cs),
            .core_y(s_y), .core_done(1'b0)
        );
        initial begin
            int            cnt;
            bit            hit;
            logic [XW-1:0] xs;
            cnt = 0;
            hit = 0;
            wait (sw_go);
            @(posedge clk);
            for (int i = 0; i < 40 && !hit; i++) begin
                @(negedge clk);
                if (s_cs) begin
                    hit = 1;
                    xs  = s_x;
                end else if (s_busy) begin
                    cnt++;
                end
            end
            if (!hit) xs = s_x;
            chk($sformatf("sweep_len_L%0d", L), cnt, N + L);
            chk($sformatf("sweep_x_L%0d", L), xs, exp_x);
        end
    end

    initial begin
        int cyc, w0, d0;
        rst_n = 1'b0; start = 1'b0; sw_start = 1'b0; sw_go = 1'b0;
        src_base = '0; dst_base = '0; exp_x = exp_src(64'd1);
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int k = 0; k < N; k++) begin
            mem[8'(16 + k)] = 64'(k + 1);
            mem[8'(32 + k)] = 64'(256 + k);
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_din", bram_din, 0);
        chk("rst_core_start", core_start, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run: src 0x10, dst 0x40.
        w0 = we_cnt;
        run(10'h010, 10'h040, cyc);
        chk("latency", cyc, 2 * N + LAT + 3 + 5);
        @(negedge clk);
        for (int k = 0; k < N; k++) chk($sformatf("wb_%0d", k), mem[8'(64 + k)], exp_wb(k, 64'd1));
        chk("core_x", core_x, exp_x);
        chk("we_cycles", we_cnt - w0, N);

        // Starts during CORE and on the done cycle must be ignored.
        d0 = done_cnt;
        launch(10'h010, 10'h080);
        for (int i = 0; i < 100 && !core_start; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(negedge clk);
        chk("one_done", done_cnt - d0, 1);
        chk("idle_after", busy, 0);
        for (int k = 0; k < N; k++) chk($sformatf("wb2_%0d", k), mem[8'(128 + k)], exp_wb(k, 64'd1));

        // Destination wrap: 253..255 then 0..4.
        for (int j = -1; j < 9; j++) mem[8'(253 + j)] = '0;
        run(10'h010, 10'd253, cyc);
        @(negedge clk);
        for (int j = 0; j < N; j++) chk($sformatf("wrap_%0d", j), mem[8'(253 + j)], exp_wb(j, 64'd1));
        chk("wrap_below", mem[252], 0);
        chk("wrap_above", mem[5], 0);

        // Reset in READ at rd_i=3, then restart from 0x20.
        for (int k = 0; k < N; k++) mem[8'(96 + k)] = '0;
        launch(10'h010, 10'h060);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_en", bram_en, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run(10'h020, 10'h060, cyc);
        chk("latency2", cyc, 2 * N + LAT + 3 + 5);
        @(negedge clk);
        for (int k = 0; k < N; k++) chk($sformatf("rst_wb_%0d", k), mem[8'(96 + k)], exp_wb(k, 64'd256));

        // RD_LAT sweep.
        @(negedge clk);
        sw_start = 1'b1;
        sw_go    = 1'b1;
        @(posedge clk);
        #1 sw_start = 1'b0;
        repeat (60) @(negedge clk);

        chk("we_outside_write", we_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ntt_bram_ctrl.md
Name: ntt_bram_ctrl

Overview:
- Parametrised BRAM-to-NTT controller, successor to the fixed 64-point loader.
- On a start pulse it streams N words from a BRAM source region into an operand buffer and launches an external NTT core.
- When the core finishes, it writes the N results back to a BRAM destination region and pulses done.
- Sits between the AXI/BRAM port and the ntt core; source/destination bases are runtime inputs, not hard-wired to 0.

Parameters:
- N, 64, transform length in words; power of two, 4..256.
- DATA_W, 64, word width in bits; multiple of 8.
- ADDR_W, 10, BRAM byte-address width.
- RD_LAT, 2, BRAM read latency in cycles from address/en to valid dout; 1..4.
- ADDR_SHIFT, 2, left shift from word index to byte address.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_base  in  ADDR_W  word index of first source word; latched at start.
- dst_base  in  ADDR_W  word index of first destination word; latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last result is written.
- bram_addr  out  ADDR_W  byte address = word_index << ADDR_SHIFT, truncated to ADDR_W.
- bram_en  out  1  BRAM enable.
- bram_we  out  DATA_W/8  byte write enables; all-ones or all-zeros.
- bram_din  out  DATA_W  write data.
- bram_dout  in  DATA_W  read data.
- core_x  out  N*DATA_W  flattened operand buffer; word k at bits [k*DATA_W +: DATA_W].
- core_start  out  1  one-cycle launch pulse to the NTT core.
- core_y  in  N*DATA_W  flattened core result; same packing as core_x.
- core_done  in  1  core result valid (level); may stay high until the next core_start.

Behaviour:
- Reset values: busy=0, done=0, bram_en=0, bram_we=0, bram_din=0, bram_addr=0, core_start=0, FSM in IDLE. The operand buffer is not cleared.
- States and transitions:
  - IDLE -> READ on start. Latch src_base and dst_base; clear the issue counter rd_i and the capture counter cap_i.
  - READ: issue one read per cycle (bram_en=1, word address src_base+rd_i) for rd_i = 0..N-1. A RD_LAT-deep valid shift register tags each issued read. When a tag emerges, bram_dout is written to x[cap_i] and cap_i increments. After cap_i reaches N, bram_en=0 and the FSM enters LAUNCH. READ lasts N+RD_LAT cycles.
  - LAUNCH: core_start=1 for exactly one cycle -> CORE.
  - CORE: wait for core_done. Sampling starts the cycle after LAUNCH, so a stale core_done from a previous run must not be seen. On core_done=1 -> WRITE.
  - WRITE: for j = 0..N-1, one word per cycle: bram_en=1, bram_we=all-ones, bram_addr from word index dst_base+j, bram_din=y[j]. core_y is sampled combinationally and must be stable while in WRITE. WRITE lasts N cycles -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Word addresses wrap modulo 2^(ADDR_W-ADDR_SHIFT); no error is raised on wrap.
- start while busy is ignored; start coincident with the done pulse is also ignored.
- Reset (rst_n=0) in any state returns to IDLE within the same clock edge. Any in-flight reads are discarded; core_start and bram_we are deasserted on that edge.
- bram_we is nonzero only in WRITE.
- Throughput: one word per cycle. Total latency from start to done = 2N + RD_LAT + 3 cycles + core time.

Optional Feature:
- BITREV_WB_EN. When defined, WRITE stores y[bitrev(j)] at dst_base+j, with bitrev over log2(N) bits, so DIT outputs land in natural order.
- When undefined, y[j] is stored at dst_base+j and no bit-reverse logic is synthesised.

Decomposition:
- Package ntt_pkg holds:
  - the state enum typedef (IDLE, READ, LAUNCH, CORE, WRITE, FIN);
  - a function clog2-based index width helper;
  - a bitrev function parameterised by bit count.
- One sub-module, bram_rd_pipe: RD_LAT-deep valid/index shift register that delivers capture strobes and target indices.

Test Plan:
- N=8, RD_LAT=2, src_base=0x10, dst_base=0x40, BRAM[0x10+k]=k+1, core model returns y[k]=2*x[k] after 5 cycles -> BRAM[0x40+k]=2k+2. done pulses exactly 2*8+2+3+5 cycles after start; bram_we is never high outside WRITE.
- RD_LAT swept 1..4 with the same data -> captured x identical in every case; READ duration = N+RD_LAT.
- dst_base = max word index - 2 with N=8 -> results written to the top 3 words then word indices 0..4 (wrap).
- rst_n=0 held for one cycle mid-READ (rd_i=3), then a new start with src_base=0x20 -> busy clears and bram_en=0 the next cycle; the second run completes with data sourced from 0x20 only.
- start asserted during CORE and on the done cycle -> ignored; exactly one done per accepted start.
- BITREV_WB_EN defined, N=8, y[k]=k -> BRAM[dst_base+j] = bitrev3(j), i.e. 0,4,2,6,1,5,3,7.
